// File: rtl/seven_seg_scanner_if.sv
// Display bus between game-state logic and the 7-segment scanner.
// master drives digit data and update; slave drives the seg/an pins.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    update;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits, dp, blank, blink, update,
        input  seg, an, frame_done
    );

    modport slave (
        input  digits, dp, blank, blink, update,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous update.
// Optional blinking is enabled by defining SEVSEG_BLINK_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input logic             clk,
    input logic             rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           nxt_idx;
    logic                    tick;
    logic                    last;
    logic                    wrap;
    logic                    cap;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [4*NUM_DIGITS-1:0] nxt_digits;
    logic [NUM_DIGITS-1:0]   nxt_dp;
    logic [NUM_DIGITS-1:0]   nxt_blank;

    logic [7:0]              seg_q;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [3:0]              nib;
    logic                    dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick    = (cnt == CW'(REFRESH_DIV - 1));
    assign last    = (idx == IW'(NUM_DIGITS - 1));
    assign wrap    = tick & last;
    assign cap     = wrap & (pending | bus.update);
    assign nxt_idx = last ? '0 : idx + 1'b1;

    // Values in force for the slot that starts after this edge; a capture
    // on the wrap must already be visible in digit 0 of the new frame.
    assign nxt_digits = cap ? bus.digits : sh_digits;
    assign nxt_dp     = cap ? bus.dp     : sh_dp;
    assign nxt_blank  = cap ? bus.blank  : sh_blank;

`ifdef SEVSEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic                  nxt_phase;
    logic [NUM_DIGITS-1:0] sh_blink;
    logic [NUM_DIGITS-1:0] nxt_blink;

    assign nxt_blink = cap ? bus.blink : sh_blink;
    assign nxt_phase = (wrap && fcnt == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;

    // Count completed frames and flip the blink phase every BLINK_FRAMES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            fcnt  <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
            phase <= nxt_phase;
        end
    end

    // Blink mask is latched with the rest of the frame data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh_blink <= '0;
        else if (cap)
            sh_blink <= bus.blink;
    end

    assign dark = nxt_blank[nxt_idx] | (nxt_phase & nxt_blink[nxt_idx]);
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink;
    assign dark = nxt_blank[nxt_idx];
`endif

    // Build the cathode/anode pattern for the upcoming slot.
    always_comb begin
        nib     = nxt_digits[4*nxt_idx +: 4];
        an_nxt  = ~(NUM_DIGITS'(1) << nxt_idx);
        seg_nxt = 8'hFF;
        if (!dark)
            seg_nxt = {~nxt_dp[nxt_idx], hex7(nib)};
    end

    // Slot prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Digit index and registered pin drive advance together on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else if (tick) begin
            idx   <= nxt_idx;
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    // Remember an update request until the next frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (cap)
            pending <= 1'b0;
        else if (bus.update)
            pending <= 1'b1;
    end

    // Shadow copy of the display data; starts dark until the first update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
        end else if (cap) begin
            sh_digits <= bus.digits;
            sh_dp     <= bus.dp;
            sh_blank  <= bus.blank;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = wrap;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: cycle model plus directed checks.
// Blink expectations follow SEVSEG_BLINK_EN when it is defined.
module tb_seven_seg_scanner;
    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int BF  = 2;

    localparam logic [6:0] SEG7 [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: n = clock edges since reset release; slot = n / DIV.
    int         n;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank, m_blink;
    bit          m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_dig = '0; m_dp = '0; m_blank = '1; m_blink = '0; m_pend = 0;
        end else begin
            if ((n % DIV == DIV-1) && ((n / DIV) % ND == ND-1)
                && (m_pend || bus.update)) begin
                m_dig = bus.digits; m_dp = bus.dp;
                m_blank = bus.blank; m_blink = bus.blink;
                m_pend = 0;
            end else if (bus.update) begin
                m_pend = 1;
            end
            n++;
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        int k, d, ph;
        logic [7:0] e_seg;
        logic [3:0] e_an;
        logic       e_fd;
        if (rst_n) begin
            k  = n / DIV;
            d  = k % ND;
            ph = 0;
`ifdef SEVSEG_BLINK_EN
            ph = ((k / ND) / BF) % 2;
`endif
            e_fd = (n % DIV == DIV-1) && (d == ND-1);
            if (k == 0) begin
                e_an = 4'hF; e_seg = 8'hFF;
            end else begin
                e_an = ~(4'b1 << d);
                if (m_blank[d] || (ph == 1 && m_blink[d]))
                    e_seg = 8'hFF;
                else
                    e_seg = {~m_dp[d], SEG7[m_dig[4*d +: 4]]};
            end
            vectors++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.frame_done !== e_fd) begin
                miscompares++;
                $display("FAIL scan n=%0d: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                         n, bus.seg, bus.an, bus.frame_done, e_seg, e_an, e_fd);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic seek_slot(input int i);
        bit ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (bus.an == ~(4'b1 << i)) ok = 1;
        end
        if (!ok) chk("seek_slot_timeout", 8'h00, 8'h01);
    endtask

    task automatic wait_fd();
        bit ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (bus.frame_done) ok = 1;
        end
        if (!ok) chk("frame_done_timeout", 8'h00, 8'h01);
    endtask

    task automatic goto_slot(input int i);
        wait_fd();
        seek_slot(i);
    endtask

    task automatic pulse_update();
        @(negedge clk) bus.update = 1'b1;
        @(negedge clk) bus.update = 1'b0;
    endtask

    initial begin
        int gap, dark;
        bus.digits = '0; bus.dp = '0; bus.blank = '0;
        bus.blink = '0; bus.update = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Dark display after reset, anodes still scanning
        seek_slot(2);
        chk("rst_slot2_seg", bus.seg, 8'hFF);
        chk("rst_slot2_an", {4'h0, bus.an}, 8'h0B);

        // 3210, frame period
        bus.digits = 16'h3210;
        pulse_update();
        goto_slot(0);
        chk("d0_3210", bus.seg, 8'hC0);
        chk("an_slot0", {4'h0, bus.an}, 8'h0E);
        seek_slot(3);
        chk("d3_3210", bus.seg, 8'hB0);
        wait_fd();
        gap = 0;
        do begin
            @(negedge clk); gap++;
        end while (!bus.frame_done && gap < 64);
        chk("frame_period", 8'(gap), 8'd16);

        // Tear-free mid-frame update
        seek_slot(0);
        bus.digits = 16'hFEDC;
        pulse_update();
        seek_slot(3);
        chk("d3_still_old", bus.seg, 8'hB0);
        goto_slot(0);
        chk("d0_C", bus.seg, 8'hC6);
        seek_slot(3);
        chk("d3_F", bus.seg, 8'h8E);

        // Blank and decimal point
        bus.digits = 16'h8888; bus.blank = 4'b0110; bus.dp = 4'b0001;
        pulse_update();
        goto_slot(0);
        chk("d0_8dp", bus.seg, 8'h00);
        seek_slot(1);
        chk("d1_blank", bus.seg, 8'hFF);
        chk("d1_an_low", {4'h0, bus.an}, 8'h0D);
        seek_slot(2);
        chk("d2_blank", bus.seg, 8'hFF);
        seek_slot(3);
        chk("d3_8", bus.seg, 8'h80);

        // Update coincident with the wrapping tick
        wait_fd();
        bus.digits = 16'h00A5; bus.blank = 4'b0000; bus.dp = 4'b0000;
        bus.update = 1'b1;
        @(negedge clk) bus.update = 1'b0;
        chk("coinc_d0", bus.seg, 8'h92);
        chk("coinc_an", {4'h0, bus.an}, 8'h0E);
        seek_slot(1);
        chk("coinc_d1", bus.seg, 8'h88);
        bus.digits = 16'h1111;
        goto_slot(0);
        chk("no_stale_pending", bus.seg, 8'h92);

        // Blink on digit 0 over four frames
        bus.blink = 4'b0001;
        pulse_update();
        goto_slot(0);
        dark = 0;
        for (int f = 0; f < 4; f++) begin
            goto_slot(0);
            if (bus.seg == 8'hFF) dark++;
        end
`ifdef SEVSEG_BLINK_EN
        chk("blink_dark_frames", 8'(dark), 8'd2);
`else
        chk("blink_dark_frames", 8'(dark), 8'd0);
`endif

        // Asynchronous reset in the middle of a scan
        seek_slot(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seg", bus.seg, 8'hFF);
        chk("async_rst_an", {4'h0, bus.an}, 8'h0F);
        @(negedge clk) rst_n = 1'b1;
        seek_slot(1);
        chk("post_rst_seg", bus.seg, 8'hFF);
        chk("post_rst_an", {4'h0, bus.an}, 8'h0D);
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
